// File: rtl/ninjakun_cpubus_resp.sv
// ninjakun_cpubus_resp
// Responder for the CPU address-decode chip selects. Services scroll register
// accesses immediately and arbitrates the shared video RAM port (FG, BG,
// sprite, palette) against the video scanner, stretching the CPU cycle with
// CPWAIT while the access is pending.
//
// Ports:
//   MCLK, RESET_N          clock, asynchronous active-low reset
//   CPADR, CPDO            CPU address and write data
//   CPRD, CPWR             CPU read / write strobes (active high)
//   CS_*                   decoded chip selects, priority SCRX>SCRY>FGV>BGV>SPA>PAL
//   CPDI, CPDV             read data (held) and one-cycle valid pulse
//   CPWAIT                 combinational CPU wait request
//   VREQ, VADR             video scanner port request and address
//   RAM_AD, RAM_WE, RAM_DO shared RAM address, per-region write enable, write data
//   RAM_DI_FG/BG/SP/PL     RAM read data, valid one cycle after the address
//   SCRX, SCRY             scroll registers
module ninjakun_cpubus_resp #(
    parameter int MAXWAIT = 15,
    parameter int AW      = 11
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic [15:0]   CPADR,
    input  logic [7:0]    CPDO,
    input  logic          CPRD,
    input  logic          CPWR,
    input  logic          CS_SCRX,
    input  logic          CS_SCRY,
    input  logic          CS_FGV,
    input  logic          CS_BGV,
    input  logic          CS_SPA,
    input  logic          CS_PAL,
    output logic [7:0]    CPDI,
    output logic          CPDV,
    output logic          CPWAIT,
    input  logic          VREQ,
    input  logic [AW-1:0] VADR,
    output logic [AW-1:0] RAM_AD,
    output logic [3:0]    RAM_WE,
    output logic [7:0]    RAM_DO,
    input  logic [7:0]    RAM_DI_FG,
    input  logic [7:0]    RAM_DI_BG,
    input  logic [7:0]    RAM_DI_SP,
    input  logic [7:0]    RAM_DI_PL,
    output logic [7:0]    SCRX,
    output logic [7:0]    SCRY
);

    localparam logic [3:0] LP_MAXWAIT = 4'(MAXWAIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAITV  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_CAPT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prev_strb;
    logic [3:0]    r_cnt;
    logic [1:0]    r_reg;
    logic [AW-1:0] r_adr;
    logic [7:0]    r_data;
    logic          r_wr;
    logic [7:0]    r_cpdi;
    logic          r_cpdv;
    logic [7:0]    r_scrx;
    logic [7:0]    r_scry;

    logic          w_strb;
    logic          w_start;
    logic          w_scr_x;
    logic          w_scr_y;
    logic          w_ram_hit;
    logic [1:0]    w_ram_reg;
    logic [3:0]    w_cnt_nxt;
    logic [7:0]    w_ram_di;
    logic          w_ram_start;
    logic          w_unused_adr;

    assign w_unused_adr = &{1'b0, CPADR[15:AW]};

    assign w_strb = CPRD | CPWR;
    // Gated by RESET_N so CPWAIT cannot assert through the start term while held in reset.
    assign w_start     = w_strb & ~r_prev_strb & RESET_N;
    assign w_ram_start = (r_state == ST_IDLE) & w_start & w_ram_hit;
    assign w_cnt_nxt   = (r_cnt >= LP_MAXWAIT) ? LP_MAXWAIT : (r_cnt + 4'd1);

    // Chip-select priority: only the highest-priority asserted select is serviced.
    always_comb begin
        w_scr_x   = 1'b0;
        w_scr_y   = 1'b0;
        w_ram_hit = 1'b0;
        w_ram_reg = 2'd0;
        if (CS_SCRX) begin
            w_scr_x = 1'b1;
        end else if (CS_SCRY) begin
            w_scr_y = 1'b1;
        end else if (CS_FGV) begin
            w_ram_hit = 1'b1;
            w_ram_reg = 2'd0;
        end else if (CS_BGV) begin
            w_ram_hit = 1'b1;
            w_ram_reg = 2'd1;
        end else if (CS_SPA) begin
            w_ram_hit = 1'b1;
            w_ram_reg = 2'd2;
        end else if (CS_PAL) begin
            w_ram_hit = 1'b1;
            w_ram_reg = 2'd3;
        end else begin
            w_ram_hit = 1'b0;
        end
    end

    // Read data mux for the latched region.
    always_comb begin
        w_ram_di = 8'h00;
        case (r_reg)
            2'd0:    w_ram_di = RAM_DI_FG;
            2'd1:    w_ram_di = RAM_DI_BG;
            2'd2:    w_ram_di = RAM_DI_SP;
            2'd3:    w_ram_di = RAM_DI_PL;
            default: w_ram_di = 8'h00;
        endcase
    end

    // Next-state and RAM-port/wait outputs.
    always_comb begin
        w_state_nxt = r_state;
        CPWAIT      = 1'b0;
        RAM_AD      = VADR;
        RAM_WE      = 4'b0000;
        RAM_DO      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_ram_start) begin
                    CPWAIT      = 1'b1;
                    w_state_nxt = VREQ ? ST_WAITV : ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAITV: begin
                CPWAIT = 1'b1;
                // Leaving on the cycle the counter reaches MAXWAIT gives exactly MAXWAIT wait cycles.
                if (!VREQ || (w_cnt_nxt == LP_MAXWAIT)) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_WAITV;
                end
            end
            ST_ACCESS: begin
                CPWAIT = 1'b1;
                RAM_AD = r_adr;
                if (r_wr) begin
                    RAM_WE = 4'b0001 << r_reg;
                    RAM_DO = r_data;
                end else begin
                    RAM_WE = 4'b0000;
                end
                w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_strb) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and strobe edge history.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_prev_strb <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_strb <= w_strb;
        end
    end

    // Video-port wait counter: cleared on entering WAITV, saturating while waiting.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= 4'd0;
        end else if (w_ram_start) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_WAITV) begin
            r_cnt <= w_cnt_nxt;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Latch the RAM access parameters at the start edge.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_reg  <= 2'd0;
            r_adr  <= '0;
            r_data <= 8'h00;
            r_wr   <= 1'b0;
        end else if (w_ram_start) begin
            r_reg  <= w_ram_reg;
            r_adr  <= CPADR[AW-1:0];
            r_data <= CPDO;
            r_wr   <= CPWR;
        end else begin
            r_reg  <= r_reg;
            r_adr  <= r_adr;
            r_data <= r_data;
            r_wr   <= r_wr;
        end
    end

    // Scroll registers and CPU read-data return.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scrx <= 8'h00;
            r_scry <= 8'h00;
            r_cpdi <= 8'h00;
            r_cpdv <= 1'b0;
        end else begin
            r_cpdv <= 1'b0;
            if ((r_state == ST_IDLE) && w_start && w_scr_x) begin
                if (CPWR) begin
                    r_scrx <= CPDO;
                end else begin
                    r_cpdi <= r_scrx;
                    r_cpdv <= 1'b1;
                end
            end else if ((r_state == ST_IDLE) && w_start && w_scr_y) begin
                if (CPWR) begin
                    r_scry <= CPDO;
                end else begin
                    r_cpdi <= r_scry;
                    r_cpdv <= 1'b1;
                end
            end else if ((r_state == ST_CAPT) && !r_wr) begin
                r_cpdi <= w_ram_di;
                r_cpdv <= 1'b1;
            end else begin
                r_cpdi <= r_cpdi;
            end
        end
    end

    assign CPDI = r_cpdi;
    assign CPDV = r_cpdv;
    assign SCRX = r_scrx;
    assign SCRY = r_scry;

endmodule
